frame_buffer_db: RTL and testbench
==================================

FRAME_BUFFER_DB -- requirements
Module: frame_buffer_db

Interface
REQ-001 SHALL have parameter PIX_W, default 3, bits per pixel.
REQ-002 SHALL have parameter H_RES, default 640, pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, lines per frame.
REQ-004 SHALL have parameter CLEAR_VAL, default 0, pixel value used by clear sweep.
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports wr_x input 10, wr_y input 9, wr_data input PIX_W: write coordinate and pixel.
REQ-008 SHALL have ports wr_valid input 1, wr_ready output 1: write handshake.
REQ-009 SHALL have ports rd_x input 10, rd_y input 9, rd_en input 1: read request.
REQ-010 SHALL have ports rd_data output PIX_W, rd_valid output 1: read response.
REQ-011 SHALL have ports swap_req input 1, rd_vblank input 1, swap_ack output 1, swap_pending output 1.
REQ-012 SHALL have ports front_sel output 1 (bank displayed) and oor_err output 1 (sticky out-of-range flag).

Function
REQ-013 SHALL hold two banks of H_RES*V_RES pixels; address = y*H_RES + x, width ADDR_W = clog2(H_RES*V_RES).
REQ-014 SHALL write wr_data to back bank (index !front_sel) on cycle where wr_valid && wr_ready.
REQ-015 SHALL register rd_en; rd_data/rd_valid SHALL appear exactly 1 cycle after rd_en, read from front bank; rd_valid low otherwise, rd_data holds last value.
REQ-016 SHALL treat x>=H_RES or y>=V_RES as out of range: write dropped, read returns 0 with rd_valid 1, oor_err set until reset.
REQ-017 SHALL implement FSM IDLE -> PENDING on swap_req; PENDING -> IDLE on first cycle with rd_vblank high, toggling front_sel that edge.
REQ-018 SHALL pulse swap_ack for exactly one cycle on the cycle after front_sel toggles; swap_pending high while in PENDING.
REQ-019 SHALL ignore swap_req while PENDING (no double swap); swap_req and rd_vblank high together in IDLE SHALL enter PENDING only, swapping next vblank cycle.
REQ-020 SHALL keep wr_ready high in IDLE and PENDING; a write in the same cycle as the toggle goes to the pre-toggle back bank.
REQ-021 SHALL make a read in the toggle cycle use the pre-toggle front bank.

Reset
REQ-022 SHALL on rst_n low force: state IDLE, front_sel 0, rd_data 0, rd_valid 0, swap_ack 0, swap_pending 0, oor_err 0, wr_ready 1; memory contents not reset.
REQ-023 SHALL on reset mid-PENDING or mid-CLEAR abandon the operation with no bank toggle.

Configuration
REQ-024 SHALL honour macro FB_CLEAR_ON_SWAP_EN.
REQ-025 With FB_CLEAR_ON_SWAP_EN: after toggle, FSM SHALL enter CLEAR, writing CLEAR_VAL to new back bank at one address per cycle from 0 to H_RES*V_RES-1, wr_ready low throughout, swap_ack pulsed the cycle after last clear write, then IDLE; swap_req during CLEAR ignored.
REQ-026 Without FB_CLEAR_ON_SWAP_EN: no CLEAR state, no sweep counter, back bank keeps prior contents.

Structure
REQ-027 SHALL place FSM state enum and address-width function in shared package fb_pkg.
REQ-028 SHALL instantiate sub-module fb_bank twice (one write port, one synchronous read port, inferred RAM).

Verification (bench with H_RES=8, V_RES=4, PIX_W=3)
REQ-029 Write (3,2)=5 to back, swap_req, rd_vblank pulse, read (3,2) -> rd_data 5 one cycle after rd_en, front_sel 1, swap_ack one-cycle pulse.
REQ-030 Read (8,0) and write (0,4) -> rd_data 0, rd_valid 1, oor_err 1 and stays 1, no bank contents changed.
REQ-031 swap_req twice before rd_vblank -> exactly one toggle, one swap_ack.
REQ-032 rst_n low while PENDING -> front_sel 0, swap_pending 0, no swap_ack after release.
REQ-033 With FB_CLEAR_ON_SWAP_EN: after swap, wr_ready low for 32 cycles, then every back-bank pixel reads CLEAR_VAL after next swap.
REQ-034 Write and toggle in same cycle -> written pixel visible in new front bank.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered frame buffer.
// Macro FB_CLEAR_ON_SWAP_EN adds the post-swap clear sweep state.
package fb_pkg;

  localparam int FB_X_W = 10;
  localparam int FB_Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1
`ifdef FB_CLEAR_ON_SWAP_EN
    ,
    ST_CLEAR   = 2'd2
`endif
  } fb_state_e;

  // Address width for a bank of 'depth' pixels, never narrower than 1 bit.
  function automatic int fb_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: single write port, single registered read port (RAM-inferable).
module fb_bank #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write and synchronous read; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_db.sv
// Double-buffered frame buffer: writes land in the back bank, reads come from
// the front bank, and a requested swap happens on the next vblank cycle.
// Macro FB_CLEAR_ON_SWAP_EN: after each swap, sweep CLEAR_VAL through the new
// back bank (one pixel per cycle, writes stalled) before acknowledging.
module frame_buffer_db
  import fb_pkg::*;
#(
  parameter int PIX_W     = 3,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int CLEAR_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        rd_x,
  input  logic [8:0]        rd_y,
  input  logic              rd_en,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              swap_req,
  input  logic              rd_vblank,
  output logic              swap_ack,
  output logic              swap_pending,
  output logic              front_sel,
  output logic              oor_err
);

  localparam int          DEPTH  = H_RES * V_RES;
  localparam int          ADDR_W = fb_addr_w(DEPTH);
  localparam logic [31:0] X_LIM  = H_RES;
  localparam logic [31:0] Y_LIM  = V_RES;

  fb_state_e state_q, state_d;
  logic      front_q, toggle;
  logic      ack_q, ack_d;
  logic      oor_q, oor_d;

  logic                   rd_valid_q, rd_oor_q, rd_bank_q;
  logic [PIX_W-1:0]       rd_hold_q, rd_fresh;

  logic                   wr_oor, rd_oor, wr_fire, rd_go;
  logic [ADDR_W-1:0]      wr_addr, rd_addr;
  logic                   we_any;
  logic [ADDR_W-1:0]      bank_waddr;
  logic [PIX_W-1:0]       bank_wdata;
  logic [1:0]             bank_we, bank_re;
  logic [1:0][PIX_W-1:0]  bank_rdata;

  // Range checks on the full coordinate; linear address only meaningful in range.
  assign wr_oor  = (32'(wr_x) >= X_LIM) || (32'(wr_y) >= Y_LIM);
  assign rd_oor  = (32'(rd_x) >= X_LIM) || (32'(rd_y) >= Y_LIM);
  assign wr_addr = ADDR_W'(wr_y) * ADDR_W'(H_RES) + ADDR_W'(wr_x);
  assign rd_addr = ADDR_W'(rd_y) * ADDR_W'(H_RES) + ADDR_W'(rd_x);
  assign wr_fire = wr_valid && wr_ready;
  assign rd_go   = rd_en && !rd_oor;

`ifdef FB_CLEAR_ON_SWAP_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_active;

  assign clr_active = (state_q == ST_CLEAR);
  assign wr_ready   = !clr_active;
  assign we_any     = clr_active || (wr_fire && !wr_oor);
  assign bank_waddr = clr_active ? clr_cnt_q : wr_addr;
  assign bank_wdata = clr_active ? PIX_W'(CLEAR_VAL) : wr_data;

  // Sweep pointer for the clear pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_cnt_q <= '0;
    else        clr_cnt_q <= clr_cnt_d;
  end
`else
  logic unused_clear_val;

  assign unused_clear_val = ^PIX_W'(CLEAR_VAL);
  assign wr_ready   = 1'b1;
  assign we_any     = wr_fire && !wr_oor;
  assign bank_waddr = wr_addr;
  assign bank_wdata = wr_data;
`endif

  // Swap FSM next state: toggle on first vblank cycle while pending.
  always_comb begin
    state_d = state_q;
    toggle  = 1'b0;
    ack_d   = 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (swap_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (rd_vblank) begin
          toggle = 1'b1;
`ifdef FB_CLEAR_ON_SWAP_EN
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
`else
          state_d = ST_IDLE;
          ack_d   = 1'b1;
`endif
        end
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = ST_IDLE;
          ack_d     = 1'b1;
          clr_cnt_d = '0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, front bank select, swap ack pulse and sticky range error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_q ^ toggle;
      ack_q   <= ack_d;
      oor_q   <= oor_d;
    end
  end

  assign oor_d = oor_q || (wr_fire && wr_oor) || (rd_en && rd_oor);

  // Writes target the back bank; reads target the front bank, both as of
  // this cycle, so a toggle edge never redirects an in-flight access.
  always_comb begin
    bank_we[0] = we_any && front_q;
    bank_we[1] = we_any && !front_q;
    bank_re[0] = rd_go && !front_q;
    bank_re[1] = rd_go && front_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank #(
      .DATA_W (PIX_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .re_i    (bank_re[b]),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  // Read response tracking: which bank answered, and whether it was out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_oor_q   <= rd_oor;
      rd_bank_q  <= front_q;
      rd_hold_q  <= rd_data;
    end
  end

  assign rd_fresh     = rd_oor_q ? '0 : bank_rdata[rd_bank_q];
  assign rd_data      = rd_valid_q ? rd_fresh : rd_hold_q;
  assign rd_valid     = rd_valid_q;
  assign swap_ack     = ack_q;
  assign swap_pending = (state_q == ST_PENDING);
  assign front_sel    = front_q;
  assign oor_err      = oor_q;

endmodule

// File: tb/tb_frame_buffer_db.sv
// Randomized bench for frame_buffer_db (8x4 pixels, 3 bits) with a
// bank-array reference model. Works with or without FB_CLEAR_ON_SWAP_EN.
module tb_frame_buffer_db;

  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;
  localparam logic [2:0] CLR = 3'd6;
`ifdef FB_CLEAR_ON_SWAP_EN
  localparam int CLR_CYC = N;
`else
  localparam int CLR_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] wr_x = '0;
  logic [8:0] wr_y = '0;
  logic [2:0] wr_data = '0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [9:0] rd_x = '0;
  logic [8:0] rd_y = '0;
  logic rd_en = 1'b0;
  logic [2:0] rd_data;
  logic rd_valid;
  logic swap_req = 1'b0;
  logic rd_vblank = 1'b0;
  logic swap_ack, swap_pending, front_sel, oor_err;

  int errs = 0;
  int checks = 0;

  logic [2:0] m_mem [2][N];
  bit m_front = 1'b0;

  frame_buffer_db #(.PIX_W(3), .H_RES(H), .V_RES(V), .CLEAR_VAL(int'(CLR))) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .swap_req(swap_req), .rd_vblank(rd_vblank), .swap_ack(swap_ack),
    .swap_pending(swap_pending), .front_sel(front_sel), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model effect of a bank swap: front flips; optional clear wipes new back.
  task automatic model_toggle();
    m_front = !m_front;
`ifdef FB_CLEAR_ON_SWAP_EN
    for (int i = 0; i < N; i++) m_mem[!m_front][i] = CLR;
`endif
  endtask

  task automatic do_write(input int x, input int y, input logic [2:0] d);
    wr_x = 10'(x); wr_y = 9'(y); wr_data = d; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    if (x < H && y < V) m_mem[!m_front][y*H + x] = d;
  endtask

  task automatic do_read(input int x, input int y, output logic [2:0] d, output logic v);
    rd_x = 10'(x); rd_y = 9'(y); rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data; v = rd_valid;
  endtask

  function automatic logic [2:0] exp_rd(input int x, input int y);
    return (x < H && y < V) ? m_mem[m_front][y*H + x] : 3'd0;
  endfunction

  // Request swap, give one vblank cycle, then count cycles to swap_ack (bounded).
  task automatic do_swap(output int ack_lat, output int ready_low);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    rd_vblank = 1'b1; tick(); rd_vblank = 1'b0;
    model_toggle();
    ack_lat = -1; ready_low = 0;
    for (int c = 0; c < 100; c++) begin
      if (!wr_ready) ready_low++;
      if (swap_ack) begin ack_lat = c; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (front_sel !== 1'b0) begin errs++; $display("FAIL reset_front got=%b exp=0", front_sel); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 3'd0) begin errs++; $display("FAIL reset_rd got=%b/%0d exp=0/0", rd_valid, rd_data); end
    checks++; if (swap_ack !== 1'b0 || swap_pending !== 1'b0) begin errs++; $display("FAIL reset_swap got ack=%b pend=%b exp=0/0", swap_ack, swap_pending); end
    checks++; if (oor_err !== 1'b0 || wr_ready !== 1'b1) begin errs++; $display("FAIL reset_misc got oor=%b rdy=%b exp=0/1", oor_err, wr_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep_front(input string tag);
    logic [2:0] d; logic v;
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      do_read(i % H, i / H, d, v);
      checks++;
      if (v !== 1'b1 || d !== exp_rd(i % H, i / H)) begin
        errs++; bad++;
        if (bad < 4) $display("FAIL sweep_%s pix=%0d got=%0d/%b exp=%0d/1", tag, i, d, v, exp_rd(i % H, i / H));
      end
    end
  endtask

  task automatic test_fill();
    int lat, low;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) do_write(i % H, i / H, 3'($urandom));
      do_swap(lat, low);
      checks++; if (lat != CLR_CYC || low != CLR_CYC) begin errs++; $display("FAIL fill_swap got lat=%0d low=%0d exp=%0d", lat, low, CLR_CYC); end
      checks++; if (front_sel !== m_front) begin errs++; $display("FAIL fill_front got=%b exp=%b", front_sel, m_front); end
      tick();
    end
    test_sweep_front("fill");
  endtask

  task automatic test_swap_basic();
    int lat, low;
    logic [2:0] d; logic v;
    do_write(3, 2, 3'd5);
    do_swap(lat, low);
    checks++; if (lat != CLR_CYC || low != CLR_CYC) begin errs++; $display("FAIL basic_ack got lat=%0d low=%0d exp=%0d", lat, low, CLR_CYC); end
    checks++; if (front_sel !== 1'b1) begin errs++; $display("FAIL basic_front got=%b exp=1", front_sel); end
    tick();
    checks++; if (swap_ack !== 1'b0) begin errs++; $display("FAIL basic_ack_pulse got=%b exp=0", swap_ack); end
    do_read(3, 2, d, v);
    checks++; if (d !== 3'd5 || v !== 1'b1) begin errs++; $display("FAIL basic_read got=%0d/%b exp=5/1", d, v); end
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 3'd5) begin errs++; $display("FAIL basic_hold got=%0d/%b exp=5/0", rd_data, rd_valid); end
  endtask

  task automatic test_random();
    int lat, low, op, x, y;
    logic [2:0] d; logic v;
    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 19));
      x = int'($urandom_range(0, H-1)); y = int'($urandom_range(0, V-1));
      if (op < 9) do_write(x, y, 3'($urandom));
      else if (op < 18) begin
        do_read(x, y, d, v);
        checks++; if (d !== exp_rd(x, y) || v !== 1'b1) begin errs++; $display("FAIL rand_read (%0d,%0d) got=%0d/%b exp=%0d/1", x, y, d, v, exp_rd(x, y)); end
      end else if (op == 18) begin
        do_swap(lat, low);
        checks++; if (lat != CLR_CYC || front_sel !== m_front) begin errs++; $display("FAIL rand_swap got lat=%0d front=%b exp=%0d/%b", lat, front_sel, CLR_CYC, m_front); end
        tick();
      end else tick();
    end
  endtask

  task automatic test_oor();
    int lat, low;
    logic [2:0] d; logic v;
    checks++; if (oor_err !== 1'b0) begin errs++; $display("FAIL oor_pre got=%b exp=0", oor_err); end
    do_read(8, 0, d, v);
    checks++; if (d !== 3'd0 || v !== 1'b1 || oor_err !== 1'b1) begin errs++; $display("FAIL oor_read got=%0d/%b/%b exp=0/1/1", d, v, oor_err); end
    do_write(0, 4, 3'd7);
    do_write(2, 1, 3'($urandom));
    repeat (5) tick();
    checks++; if (oor_err !== 1'b1) begin errs++; $display("FAIL oor_sticky got=%b exp=1", oor_err); end
    do_swap(lat, low);
    tick();
    test_sweep_front("oor");
  endtask

  task automatic test_double_swap();
    int acks = 0, lat = -1;
    swap_req = 1'b1; tick(); tick(); swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errs++; $display("FAIL dbl_pending got=%b exp=1", swap_pending); end
    rd_vblank = 1'b1; tick(); rd_vblank = 1'b0;
    model_toggle();
    for (int c = 0; c < 60; c++) begin
      if (swap_ack) acks++;
      if (front_sel !== m_front) begin errs++; $display("FAIL dbl_front c=%0d got=%b exp=%b", c, front_sel, m_front); end
      tick();
    end
    checks++; if (acks != 1) begin errs++; $display("FAIL dbl_acks got=%0d exp=1", acks); end
    checks++; if (swap_pending !== 1'b0) begin errs++; $display("FAIL dbl_idle got=%b exp=0", swap_pending); end
    // swap_req together with vblank in IDLE only arms the swap
    swap_req = 1'b1; rd_vblank = 1'b1; tick(); swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1 || front_sel !== m_front) begin errs++; $display("FAIL sim_arm got pend=%b front=%b exp=1/%b", swap_pending, front_sel, m_front); end
    tick(); rd_vblank = 1'b0;
    model_toggle();
    checks++; if (front_sel !== m_front) begin errs++; $display("FAIL sim_front got=%b exp=%b", front_sel, m_front); end
    for (int c = 0; c < 100; c++) begin
      if (swap_ack) begin lat = c; break; end
      tick();
    end
    checks++; if (lat != CLR_CYC) begin errs++; $display("FAIL sim_ack got=%0d exp=%0d", lat, CLR_CYC); end
    tick();
  endtask

  task automatic test_write_toggle();
    logic [2:0] d, old, nv; logic v;
    int lat = -1;
    nv = 3'($urandom);
    old = m_mem[m_front][1*H + 5];
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    wr_x = 10'd5; wr_y = 9'd1; wr_data = nv; wr_valid = 1'b1;
    rd_x = 10'd5; rd_y = 9'd1; rd_en = 1'b1;
    rd_vblank = 1'b1;
    tick();
    wr_valid = 1'b0; rd_en = 1'b0; rd_vblank = 1'b0;
    m_mem[!m_front][1*H + 5] = nv;
    model_toggle();
    checks++; if (rd_data !== old || rd_valid !== 1'b1) begin errs++; $display("FAIL tog_read got=%0d/%b exp=%0d/1", rd_data, rd_valid, old); end
    for (int c = 0; c < 100; c++) begin
      if (swap_ack) begin lat = c; break; end
      tick();
    end
    checks++; if (lat != CLR_CYC) begin errs++; $display("FAIL tog_ack got=%0d exp=%0d", lat, CLR_CYC); end
    do_read(5, 1, d, v);
    checks++; if (d !== nv || v !== 1'b1) begin errs++; $display("FAIL tog_write got=%0d/%b exp=%0d/1", d, v, nv); end
  endtask

  task automatic test_reset_pending();
    int acks = 0;
    logic [2:0] d; logic v;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    checks++; if (swap_pending !== 1'b1) begin errs++; $display("FAIL rstp_pending got=%b exp=1", swap_pending); end
    rst_n = 1'b0; #2;
    checks++; if (front_sel !== 1'b0 || swap_pending !== 1'b0 || oor_err !== 1'b0 || rd_data !== 3'd0) begin
      errs++; $display("FAIL rstp_during got front=%b pend=%b oor=%b rd=%0d exp=0/0/0/0", front_sel, swap_pending, oor_err, rd_data);
    end
    #2 rst_n = 1'b1;
    m_front = 1'b0;
    tick();
    rd_vblank = 1'b1; tick(); tick(); rd_vblank = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (swap_ack) acks++;
      tick();
    end
    checks++; if (acks != 0 || front_sel !== 1'b0 || swap_pending !== 1'b0) begin
      errs++; $display("FAIL rstp_after got acks=%0d front=%b pend=%b exp=0/0/0", acks, front_sel, swap_pending);
    end
    do_read(6, 3, d, v);
    checks++; if (d !== exp_rd(6, 3) || v !== 1'b1) begin errs++; $display("FAIL rstp_mem got=%0d/%b exp=%0d/1", d, v, exp_rd(6, 3)); end
  endtask

`ifdef FB_CLEAR_ON_SWAP_EN
  task automatic test_clear();
    int lat = -1, low = 0, bad = 0;
    logic [2:0] d; logic v;
    for (int i = 0; i < N; i++) do_write(i % H, i / H, 3'($urandom));
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    rd_vblank = 1'b1; tick(); rd_vblank = 1'b0;
    model_toggle();
    for (int c = 0; c < 100; c++) begin
      swap_req = (c == 5);
      if (!wr_ready) low++;
      if (swap_ack) begin lat = c; break; end
      tick();
    end
    swap_req = 1'b0;
    checks++; if (lat != N || low != N) begin errs++; $display("FAIL clr_len got lat=%0d low=%0d exp=%0d", lat, low, N); end
    tick();
    checks++; if (swap_pending !== 1'b0) begin errs++; $display("FAIL clr_req_ignored got=%b exp=0", swap_pending); end
    do_swap(lat, low);
    tick();
    for (int i = 0; i < N; i++) begin
      do_read(i % H, i / H, d, v);
      checks++;
      if (d !== CLR || v !== 1'b1) begin errs++; bad++; if (bad < 4) $display("FAIL clr_pix %0d got=%0d exp=%0d", i, d, CLR); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_swap_basic();
    test_random();
    test_oor();
    test_double_swap();
    test_write_toggle();
    test_reset_pending();
`ifdef FB_CLEAR_ON_SWAP_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
